// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: issue stage that sits in front of the register scoreboard.
// Decoded instructions are buffered in a DEPTH-entry FIFO that accepts up to
// two entries per cycle. The two head entries are presented to the scoreboard,
// up to two are issued in order each cycle, and the issued instructions are
// captured with their tracking IDs in an output register for execute.
// Build option: define DUAL_ISSUE_EN to let lane 1 issue alongside lane 0.
// Without it the stage issues at most one instruction per cycle.
// rst_n is a synchronous, active-high reset despite its name.

module dual_issue_ctrl #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic [1:0]             dec_valid_i,
    input  logic [2*PAYLOAD_W-1:0] dec_payload_i,
    input  logic [19:0]            dec_rs_i,
    input  logic [9:0]             dec_rd_i,
    input  logic [1:0]             dec_single_i,
    output logic                   dec_ready_o,
    output logic [19:0]            is_r_addr_o,
    input  logic [15:0]            is_r_id_i,
    input  logic [3:0]             is_r_valid_i,
    output logic [9:0]             is_w_addr_o,
    output logic [1:0]             is_o,
    input  logic [2:0]             is_w_id_i,
    input  logic                   issue_ready_i,
    output logic [1:0]             ex_valid_o,
    output logic [2*PAYLOAD_W-1:0] ex_payload_o,
    output logic [15:0]            ex_r_id_o,
    output logic [3:0]             ex_w_id_o,
    input  logic                   ex_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

`ifdef DUAL_ISSUE_EN
    localparam bit DualEn = 1'b1;
`else
    localparam bit DualEn = 1'b0;
`endif

    // FIFO storage, split per field
    logic [PAYLOAD_W-1:0] mem_payload [DEPTH];
    logic [4:0]           mem_rs0     [DEPTH];
    logic [4:0]           mem_rs1     [DEPTH];
    logic [4:0]           mem_rd      [DEPTH];
    logic                 mem_single  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [PW-1:0] wr_ptr1;
    logic [PW-1:0] rd_ptr1;
    logic          have0;
    logic          have1;

    logic [4:0] e0_rs0, e0_rs1, e0_rd;
    logic [4:0] e1_rs0, e1_rs1, e1_rd;
    logic       e0_single, e1_single;

    logic          enq_fire;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] iss_n;
    logic          can_issue;
    logic          ok0;
    logic          ok1;
    logic          raw_hazard;
    logic          waw_hazard;

    assign wr_ptr1 = wr_ptr + PW'(1);
    assign rd_ptr1 = rd_ptr + PW'(1);
    assign have0   = (count >= CW'(1));
    assign have1   = (count >= CW'(2));

    // Free-slot check uses only the registered count, so a same-cycle
    // dequeue never lets an enqueue in early.
    assign dec_ready_o = (count <= CW'(DEPTH - 2));

    assign enq_fire = dec_valid_i[0] & dec_ready_o & ~flush_i;
    assign enq_n    = enq_fire ? (CW'(1) + CW'(dec_valid_i[1])) : CW'(0);

    // Head-entry fields; an absent entry reads as all zeros
    always_comb begin
        e0_rs0    = 5'd0;
        e0_rs1    = 5'd0;
        e0_rd     = 5'd0;
        e0_single = 1'b0;
        e1_rs0    = 5'd0;
        e1_rs1    = 5'd0;
        e1_rd     = 5'd0;
        e1_single = 1'b0;
        if (have0) begin
            e0_rs0    = mem_rs0[rd_ptr];
            e0_rs1    = mem_rs1[rd_ptr];
            e0_rd     = mem_rd[rd_ptr];
            e0_single = mem_single[rd_ptr];
        end
        if (have1) begin
            e1_rs0    = mem_rs0[rd_ptr1];
            e1_rs1    = mem_rs1[rd_ptr1];
            e1_rd     = mem_rd[rd_ptr1];
            e1_single = mem_single[rd_ptr1];
        end
    end

    assign is_r_addr_o = DualEn ? {e1_rs1, e1_rs0, e0_rs1, e0_rs0}
                                : {10'd0, e0_rs1, e0_rs0};
    assign is_w_addr_o = {e1_rd, e0_rd};

    // A nonzero e0 destination blocks pairing if e1 reads or rewrites it
    assign raw_hazard = (e0_rd != 5'd0) && ((e0_rd == e1_rs0) || (e0_rd == e1_rs1));
    assign waw_hazard = (e0_rd != 5'd0) && (e0_rd == e1_rd);

    assign can_issue = issue_ready_i & (~|ex_valid_o | ex_ready_i) & ~flush_i;
    assign ok0 = can_issue & have0 & (is_r_valid_i[1:0] == 2'b11);
    assign ok1 = DualEn & ok0 & have1 & ~e0_single & ~e1_single
               & (is_r_valid_i[3:2] == 2'b11) & ~raw_hazard & ~waw_hazard;

    assign is_o  = {ok1, ok0};
    assign iss_n = CW'(ok0) + CW'(ok1);

    // FIFO payload/address storage; contents are only meaningful under count
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_payload[wr_ptr] <= dec_payload_i[PAYLOAD_W-1:0];
            mem_rs0[wr_ptr]     <= dec_rs_i[4:0];
            mem_rs1[wr_ptr]     <= dec_rs_i[9:5];
            mem_rd[wr_ptr]      <= dec_rd_i[4:0];
            mem_single[wr_ptr]  <= dec_single_i[0];
            if (dec_valid_i[1]) begin
                mem_payload[wr_ptr1] <= dec_payload_i[2*PAYLOAD_W-1:PAYLOAD_W];
                mem_rs0[wr_ptr1]     <= dec_rs_i[14:10];
                mem_rs1[wr_ptr1]     <= dec_rs_i[19:15];
                mem_rd[wr_ptr1]      <= dec_rd_i[9:5];
                mem_single[wr_ptr1]  <= dec_single_i[1];
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush drops everything queued
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq_n);
            rd_ptr <= rd_ptr + PW'(iss_n);
            count  <= count + enq_n - iss_n;
        end
    end

    // Output register: load on accept, hold on stall, drain when execute takes it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ex_valid_o   <= 2'b00;
            ex_payload_o <= '0;
            ex_r_id_o    <= '0;
            ex_w_id_o    <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 2'b00;
        end else if (can_issue) begin
            ex_valid_o <= {ok1, ok0};
            ex_w_id_o  <= {is_w_id_i, 1'b0};
            if (ok0) begin
                ex_payload_o[PAYLOAD_W-1:0] <= mem_payload[rd_ptr];
                ex_r_id_o[7:0]              <= is_r_id_i[7:0];
            end
            if (ok1) begin
                ex_payload_o[2*PAYLOAD_W-1:PAYLOAD_W] <= mem_payload[rd_ptr1];
                ex_r_id_o[15:8]                       <= is_r_id_i[15:8];
            end
        end else if (ex_ready_i) begin
            ex_valid_o <= 2'b00;
        end
    end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb_dual_issue_ctrl: directed bench for dual_issue_ctrl (DEPTH=8, PAYLOAD_W=32).
// Expectations follow the DUAL_ISSUE_EN setting of the build.

module tb_dual_issue_ctrl;

`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [1:0]  dec_valid_i;
    logic [63:0] dec_payload_i;
    logic [19:0] dec_rs_i;
    logic [9:0]  dec_rd_i;
    logic [1:0]  dec_single_i;
    logic        dec_ready_o;
    logic [19:0] is_r_addr_o;
    logic [15:0] is_r_id_i;
    logic [3:0]  is_r_valid_i;
    logic [9:0]  is_w_addr_o;
    logic [1:0]  is_o;
    logic [2:0]  is_w_id_i;
    logic        issue_ready_i;
    logic [1:0]  ex_valid_o;
    logic [63:0] ex_payload_o;
    logic [15:0] ex_r_id_o;
    logic [3:0]  ex_w_id_o;
    logic        ex_ready_i;

    int compared   = 0;
    int mismatched = 0;

    dual_issue_ctrl #(.DEPTH(8), .PAYLOAD_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .dec_valid_i   (dec_valid_i),
        .dec_payload_i (dec_payload_i),
        .dec_rs_i      (dec_rs_i),
        .dec_rd_i      (dec_rd_i),
        .dec_single_i  (dec_single_i),
        .dec_ready_o   (dec_ready_o),
        .is_r_addr_o   (is_r_addr_o),
        .is_r_id_i     (is_r_id_i),
        .is_r_valid_i  (is_r_valid_i),
        .is_w_addr_o   (is_w_addr_o),
        .is_o          (is_o),
        .is_w_id_i     (is_w_id_i),
        .issue_ready_i (issue_ready_i),
        .ex_valid_o    (ex_valid_o),
        .ex_payload_o  (ex_payload_o),
        .ex_r_id_o     (ex_r_id_o),
        .ex_w_id_o     (ex_w_id_o),
        .ex_ready_i    (ex_ready_i)
    );

    always #5 clk = ~clk;

    // Lane 1 alone is never a legal enqueue request
    always @(posedge clk) begin
        assert (dec_valid_i !== 2'b10) else $error("[TB] illegal dec_valid_i 2'b10 driven");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [4:0] a0, input logic [4:0] b0, input logic [4:0] d0,
                                 input logic [4:0] a1, input logic [4:0] b1, input logic [4:0] d1,
                                 input logic [1:0] s);
        dec_valid_i   = v;
        dec_payload_i = {p1, p0};
        dec_rs_i      = {b1, a1, b0, a0};
        dec_rd_i      = {d1, d0};
        dec_single_i  = s;
    endtask

    initial begin : main
        int cnt;
        int head;
        int n;
        logic [1:0] exp_is;
        logic [31:0] base;

        rst_n = 1'b1; flush_i = 1'b0; is_r_id_i = 16'h0; is_r_valid_i = 4'hF;
        is_w_id_i = 3'b101; issue_ready_i = 1'b1; ex_ready_i = 1'b1;
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // reset state
        tick(); tick();
        checkOutput("rst_ex_valid", 64'(ex_valid_o), 64'd0);
        checkOutput("rst_dec_ready", 64'(dec_ready_o), 64'd1);
        checkOutput("rst_is_o", 64'(is_o), 64'd0);
        checkOutput("rst_r_addr", 64'(is_r_addr_o), 64'd0);
        checkOutput("rst_w_id", 64'(ex_w_id_o), 64'd0);
        rst_n = 1'b0;
        tick();

        // independent pair
        applyStimulus(2'b11, 32'hA000_0000, 32'hA000_0001, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7, 5'd4, 2'b00);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        is_r_id_i = 16'hDCBA;
        settle();
        checkOutput("pair_is_o", 64'(is_o), DUAL ? 64'd3 : 64'd1);
        checkOutput("pair_r_addr", 64'(is_r_addr_o),
                    DUAL ? 64'({5'd7, 5'd6, 5'd2, 5'd1}) : 64'({10'd0, 5'd2, 5'd1}));
        checkOutput("pair_w_addr", 64'(is_w_addr_o), 64'({5'd4, 5'd3}));
        tick();
        checkOutput("pair_ex_valid", 64'(ex_valid_o), DUAL ? 64'd3 : 64'd1);
        checkOutput("pair_ex_pay0", 64'(ex_payload_o[31:0]), 64'hA000_0000);
        checkOutput("pair_ex_w_id", 64'(ex_w_id_o), 64'hA);
        checkOutput("pair_ex_r_id0", 64'(ex_r_id_o[7:0]), 64'hBA);
        if (DUAL) begin
            checkOutput("pair_ex_pay1", 64'(ex_payload_o[63:32]), 64'hA000_0001);
            checkOutput("pair_ex_r_id1", 64'(ex_r_id_o[15:8]), 64'hDC);
        end
        checkOutput("pair_is_o_next", 64'(is_o), DUAL ? 64'd0 : 64'd1);
        tick();
        checkOutput("pair_ex_valid_next", 64'(ex_valid_o), DUAL ? 64'd0 : 64'd1);
        tick();
        checkOutput("pair_ex_drained", 64'(ex_valid_o), 64'd0);
        checkOutput("pair_is_o_idle", 64'(is_o), 64'd0);

        // RAW-dependent pair: e1 reads e0's destination
        applyStimulus(2'b11, 32'hB000_0000, 32'hB000_0001, 5'd1, 5'd2, 5'd5, 5'd5, 5'd8, 5'd9, 2'b00);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        settle();
        checkOutput("raw_is_o", 64'(is_o), 64'd1);
        checkOutput("raw_w_addr", 64'(is_w_addr_o), 64'({5'd9, 5'd5}));
        tick();
        checkOutput("raw_ex_valid", 64'(ex_valid_o), 64'd1);
        checkOutput("raw_ex_pay0", 64'(ex_payload_o[31:0]), 64'hB000_0000);
        checkOutput("raw_is_o_second", 64'(is_o), 64'd1);
        checkOutput("raw_r_addr_second", 64'(is_r_addr_o[9:0]), 64'({5'd8, 5'd5}));
        tick();
        checkOutput("raw_ex_pay_second", 64'(ex_payload_o[31:0]), 64'hB000_0001);
        tick();

        // single-issue marker on e0 blocks pairing
        applyStimulus(2'b11, 32'hC500_0000, 32'hC500_0001, 5'd1, 5'd2, 5'd3, 5'd6, 5'd7, 5'd4, 2'b01);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        settle();
        checkOutput("single_is_o", 64'(is_o), 64'd1);
        tick(); tick(); tick();
        checkOutput("single_empty", 64'(is_o), 64'd0);

        // source not ready for 3 cycles
        is_r_valid_i = 4'b1110;
        applyStimulus(2'b11, 32'hC000_0000, 32'hC000_0001, 5'd1, 5'd2, 5'd10, 5'd11, 5'd12, 5'd13, 2'b00);
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        settle();
        checkOutput("wait_is_o_c1", 64'(is_o), 64'd0);
        tick();
        checkOutput("wait_is_o_c2", 64'(is_o), 64'd0);
        tick();
        checkOutput("wait_is_o_c3", 64'(is_o), 64'd0);
        checkOutput("wait_ex_valid", 64'(ex_valid_o), 64'd0);
        tick();
        is_r_valid_i = 4'hF;
        settle();
        checkOutput("wait_is_o_c4", 64'(is_o), DUAL ? 64'd3 : 64'd1);
        tick();
        checkOutput("wait_ex_valid_load", 64'(ex_valid_o), DUAL ? 64'd3 : 64'd1);
        checkOutput("wait_ex_pay0", 64'(ex_payload_o[31:0]), 64'hC000_0000);
        tick();
        checkOutput("wait_ex_valid_t2", 64'(ex_valid_o), DUAL ? 64'd0 : 64'd1);
        tick();
        checkOutput("wait_ex_valid_t3", 64'(ex_valid_o), 64'd0);

        // three fill/drain rounds of 7 entries so the pointers wrap
        for (int r = 0; r < 3; r++) begin
            issue_ready_i = 1'b0;
            base = 32'hD000_0000 + 32'(r * 16);
            for (int i = 0; i < 8; i++) begin
                applyStimulus(2'b01, base + 32'(i), 0, 5'd0, 5'd0, 5'(i + 1), 0, 0, 0, 2'b00);
                settle();
                checkOutput($sformatf("fill_r%0d_ready_%0d", r, i), 64'(dec_ready_o), (i < 7) ? 64'd1 : 64'd0);
                tick();
            end
            applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
            settle();
            checkOutput($sformatf("fill_r%0d_full", r), 64'(dec_ready_o), 64'd0);
            checkOutput($sformatf("fill_r%0d_is_o", r), 64'(is_o), 64'd0);
            issue_ready_i = 1'b1;
            settle();
            cnt = 7;
            head = 0;
            for (int k = 0; k < 10 && cnt > 0; k++) begin
                exp_is = (DUAL && cnt >= 2) ? 2'b11 : 2'b01;
                n = (exp_is == 2'b11) ? 2 : 1;
                checkOutput($sformatf("drain_r%0d_is_o_%0d", r, k), 64'(is_o), 64'(exp_is));
                tick();
                checkOutput($sformatf("drain_r%0d_pay0_%0d", r, k), 64'(ex_payload_o[31:0]), 64'(base + 32'(head)));
                if (n == 2)
                    checkOutput($sformatf("drain_r%0d_pay1_%0d", r, k), 64'(ex_payload_o[63:32]), 64'(base + 32'(head + 1)));
                head += n;
                cnt -= n;
            end
            checkOutput($sformatf("drain_r%0d_done", r), 64'(cnt), 64'd0);
            tick();
            checkOutput($sformatf("drain_r%0d_ex_idle", r), 64'(ex_valid_o), 64'd0);
            checkOutput($sformatf("drain_r%0d_ready", r), 64'(dec_ready_o), 64'd1);
        end

        // execute back-pressure, then flush
        applyStimulus(2'b11, 32'hE000_0000, 32'hE000_0001, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b00);
        ex_ready_i = 1'b0;
        tick();
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        settle();
        checkOutput("stall_is_o_first", 64'(is_o), DUAL ? 64'd3 : 64'd1);
        tick();
        checkOutput("stall_ex_valid", 64'(ex_valid_o), DUAL ? 64'd3 : 64'd1);
        checkOutput("stall_is_o_blocked", 64'(is_o), 64'd0);
        tick();
        checkOutput("stall_ex_valid_hold", 64'(ex_valid_o), DUAL ? 64'd3 : 64'd1);
        checkOutput("stall_ex_pay_hold", 64'(ex_payload_o[31:0]), 64'hE000_0000);
        checkOutput("stall_ex_w_id_hold", 64'(ex_w_id_o), 64'hA);
        flush_i = 1'b1;
        applyStimulus(2'b11, 32'hF000_0000, 32'hF000_0001, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b00);
        settle();
        checkOutput("flush_is_o", 64'(is_o), 64'd0);
        tick();
        flush_i = 1'b0;
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        settle();
        checkOutput("flush_ex_valid", 64'(ex_valid_o), 64'd0);
        checkOutput("flush_dec_ready", 64'(dec_ready_o), 64'd1);
        checkOutput("flush_is_o_empty", 64'(is_o), 64'd0);
        ex_ready_i = 1'b1;

        // reset in the middle of traffic with 5 entries queued
        issue_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 32'h5000_0000 + 32'(i), 0, 5'd0, 5'd0, 5'(i + 1), 0, 0, 0, 2'b00);
            tick();
        end
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        settle();
        checkOutput("mid_ready_5", 64'(dec_ready_o), 64'd1);
        ex_ready_i = 1'b0;
        issue_ready_i = 1'b1;
        settle();
        checkOutput("mid_is_o", 64'(is_o), DUAL ? 64'd3 : 64'd1);
        tick();
        checkOutput("mid_ex_valid", 64'(ex_valid_o), DUAL ? 64'd3 : 64'd1);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        settle();
        checkOutput("mid_rst_ex_valid", 64'(ex_valid_o), 64'd0);
        checkOutput("mid_rst_is_o", 64'(is_o), 64'd0);
        checkOutput("mid_rst_ready", 64'(dec_ready_o), 64'd1);
        checkOutput("mid_rst_r_addr", 64'(is_r_addr_o), 64'd0);
        checkOutput("mid_rst_w_addr", 64'(is_w_addr_o), 64'd0);
        checkOutput("mid_rst_payload", ex_payload_o, 64'd0);
        checkOutput("mid_rst_w_id", 64'(ex_w_id_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
- Issue stage directly upstream of the register scoreboard.
- Buffers decoded instructions in a small 2-in FIFO and presents the head two entries' register addresses to the scoreboard.
- Decides each cycle how many entries (0/1/2) to issue and drives the scoreboard `is_i`/write-address inputs.
- Registers issued instructions with their source/destination tracking IDs for the execute stage.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥4.
- PAYLOAD_W, 32, opaque decoded-instruction payload width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-high (asserted = 1)
- flush_i  in  1  pipeline flush; empties FIFO and output register
- dec_valid_i  in  2  enqueue lanes; lane1 valid only with lane0
- dec_payload_i  in  2×PAYLOAD_W  payload per lane
- dec_rs_i  in  2×2×5  source register addresses per lane
- dec_rd_i  in  2×5  destination register (0 = none)
- dec_single_i  in  2  entry must issue alone (CSR, branch, mem-barrier)
- dec_ready_o  out  1  high when ≥2 slots free
- is_r_addr_o  out  4×5  scoreboard read addresses {e1.rs1, e1.rs0, e0.rs1, e0.rs0}
- is_r_id_i  in  4×4  scoreboard tracking IDs
- is_r_valid_i  in  4  source data committed
- is_w_addr_o  out  2×5  head-entry rd, lanes 0/1
- is_o  out  2  issue strobes to scoreboard
- is_w_id_i  in  3  current tid from scoreboard
- issue_ready_i  in  1  scoreboard not in invalidate-wait
- ex_valid_o  out  2  output register valid per lane
- ex_payload_o  out  2×PAYLOAD_W
- ex_r_id_o  out  2×2×4  captured source IDs
- ex_w_id_o  out  4  {tid, lane} of lane 0; lane1 uses `{tid, 1}`
- ex_ready_i  in  1  execute accepts output register

Behaviour:
- Reset:
  - FIFO count = 0; read and write pointers = 0.
  - `ex_valid_o = 0`; `dec_ready_o = 1`; `is_o = 0`.
  - All other outputs 0.
- Enqueue:
  - Fires when `dec_valid_i[0] & dec_ready_o`.
  - Writes 1 or 2 entries in lane order at the write pointer; pointer wraps modulo DEPTH.
  - `dec_valid_i = 2'b10` is illegal; the bench asserts against it.
- Scoreboard read:
  - Combinational from entry0/entry1 at the read pointer.
  - Addresses of absent entries = 0.
- Output register accept: `can_issue = issue_ready_i & (~|ex_valid_o | ex_ready_i) & ~flush_i`.
- Lane 0 issue (`ok0`):
  - `can_issue`;
  - FIFO count ≥1;
  - `is_r_valid_i[1:0] == 2'b11`.
- Lane 1 issue (`ok1`), all of:
  - `ok0`;
  - count ≥2;
  - `~single0 & ~single1`;
  - `is_r_valid_i[3:2] == 2'b11`;
  - no RAW: `e0.rd == 0` or `e0.rd` ≠ either `e1.rs`;
  - no WAW: `e0.rd == 0` or `e0.rd ≠ e1.rd`.
- Issue strobes: `is_o = {ok1, ok0}` (in-order; never `2'b10`). The read pointer advances by `ok0 + ok1`.
- Output register load on `can_issue`:
  - `ex_valid_o ← {ok1, ok0}`.
  - Payload and r_ids captured.
  - `ex_w_id_o ← {is_w_id_i, 0}`.
- Stall: if `~can_issue` and `ex_valid_o ≠ 0`, hold all `ex_*`.
- Drain: if `ex_ready_i` and no issue, `ex_valid_o ← 0`.
- Simultaneous enqueue and issue in one cycle: `count_next = count + enq − iss`, saturating impossible by construction.
- `dec_ready_o`:
  - Computed from the registered count: `DEPTH − count ≥ 2`.
  - Does not use same-cycle dequeue.
- `flush_i`:
  - Count, pointers and `ex_valid_o` cleared next edge.
  - Enqueue that cycle discarded.
  - `is_o = 0` that cycle.
- `issue_ready_i` low: no issue; FIFO continues to accept until full.
- Reset mid-operation: identical to reset; all in-flight entries lost.

Optional Feature:
- Macro: `DUAL_ISSUE_EN`.
- Defined: lane 1 issue as above.
- Undefined:
  - `ok1` forced 0 and `is_o[1]`/`ex_valid_o[1]` constant 0.
  - `is_r_addr_o[3:2]` driven 0.
  - Max throughput 1/cycle; all other behaviour unchanged.

Test Plan:
- Enqueue 2 independent ops (rd=3, rd=4; sources ready) with `ex_ready_i=1` → next cycle `is_o=2'b11`, `ex_valid_o=2'b11`, `ex_w_id_o={is_w_id_i,0}`.
- Pair with e0.rd=5, e1.rs0=5 → `is_o=2'b01`; e1 issues the following cycle as lane 0.
- `is_r_valid_i[0]=0` for 3 cycles → `is_o=0` for 3 cycles; `ex_valid_o` drains to 0; issue resumes on the 4th cycle.
- Fill FIFO (DEPTH=8) with `issue_ready_i=0` → `dec_ready_o` falls at count 7; count never exceeds 8; pointers wrap correctly after 3 fill/drain rounds.
- `ex_ready_i=0` with valid output → `ex_*` stable and `is_o=0`; `flush_i` pulse → next cycle count=0, `ex_valid_o=0`, `dec_ready_o=1`.
- Assert `rst_n=1` mid-stream with 5 entries queued → next cycle all state at reset values.
